stimulus_encoder: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/key_debounce.sv | 30 +++
 rtl/stimulus_encoder.sv | 33 +++
 tb/tb_stimulus_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: stimulus bit indices and defaults shared by the encoder and control_fsm
package stopwatch_pkg;
  localparam int NUM_KEYS = 4;
  localparam int STIM_START_PAUSE = 3;
  localparam int STIM_LAP = 2;
  localparam int STIM_RESET = 1;
  localparam int STIM_CLEAR = 0;
  localparam int DEBOUNCE_DEFAULT = 1000000;
  typedef logic [NUM_KEYS-1:0] stim_t;
  function automatic stim_t first_set(stim_t p);
    return p[STIM_START_PAUSE] ? stim_t'(4'b1000) :
           p[STIM_LAP]         ? stim_t'(4'b0100) :
           p[STIM_RESET]       ? stim_t'(4'b0010) :
           p[STIM_CLEAR]       ? stim_t'(4'b0001) : stim_t'(4'b0000);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser and stable-count debouncer for one active-low key
module key_debounce import stopwatch_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic meta, sample, level_n, expire;
  logic [CNT_W-1:0] count;
  assign expire = (sample != level_n) && (count == CNT_W'(DEBOUNCE_CYCLES - 1));
  // level_n starts low (pressed) so a key held through reset never yields an event
  always_ff @(posedge clock)
    if (!reset_n) begin
      meta <= 1'b1;
      sample <= 1'b1;
      level_n <= 1'b0;
      count <= '0;
    end else begin
      meta <= key_n;
      sample <= meta;
      level_n <= expire ? sample : level_n;
      count <= (sample == level_n || expire) ? '0 : count + 1'b1;
    end
  assign level = ~level_n;
  assign press = expire & ~sample;
endmodule

// File: rtl/stimulus_encoder.sv
// stimulus_encoder: debounced key presses queued into one-hot, priority-ordered stimulus pulses
module stimulus_encoder import stopwatch_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] stimulus,
  output logic [3:0] pending
);
  logic [3:0] level, press, grant;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock(clock),
      .reset_n(reset_n),
      .key_n(key_n[i]),
      .level(level[i]),
      .press(press[i])
    );
  end
  assign grant = first_set(pending);
  // a press landing on its own grant edge survives the clear and is reissued
  always_ff @(posedge clock)
    if (!reset_n) begin
      pending <= '0;
      stimulus <= '0;
    end else begin
      stimulus <= grant;
      pending <= (pending & ~grant) | press;
    end
  assert property (@(posedge clock) disable iff (!reset_n) $onehot0(stimulus));
  assert property (@(posedge clock) disable iff (!reset_n) (press & level) == 4'b0000);
endmodule

// File: tb/tb_stimulus_encoder.sv
// tb_stimulus_encoder: table vectors, corner sequences and random keys against a window-based model
module tb_stimulus_encoder;
  localparam int D = 4;
  localparam logic [3:0] F = 4'b1111;
  typedef struct {logic [3:0] k; logic [3:0] s; logic [3:0] p;} vec_t;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [3:0] key_n = F, key2 = F, stimulus, pending, stim2, pend2;
  int total = 0, bad = 0;
  logic [3:0] lv, mpend, mstim;
  logic [3:0] seen[$];
  logic [3:0] xq[$];
  vec_t tv[$], sim[$], sw[$];

  stimulus_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset_n(reset_n), .key_n(key_n), .stimulus(stimulus), .pending(pending));
  stimulus_encoder #(.DEBOUNCE_CYCLES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .key_n(key2), .stimulus(stim2), .pending(pend2));

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask

  task automatic chk_int(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  // Model: a level change is accepted once the last D synchronised samples all differ from it
  task automatic model_edge(input logic [3:0] k, input logic r);
    logic [3:0] x, ev, g;
    bit differ;
    if (!r) begin
      lv = 4'b0000; mpend = 4'b0000; mstim = 4'b0000;
      seen.delete(); seen.push_back(F); seen.push_back(F);
      xq.delete();
    end else begin
      x = seen[0];
      seen.pop_front(); seen.push_back(k);
      xq.push_back(x);
      if (xq.size() > D) xq.pop_front();
      ev = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        differ = (xq.size() == D);
        for (int j = 0; j < xq.size(); j++) if (xq[j][i] == lv[i]) differ = 0;
        if (differ) begin
          lv[i] = ~lv[i];
          if (!lv[i]) ev[i] = 1'b1;
        end
      end
      g = 4'b0000;
      for (int i = 0; i < 4; i++) if (mpend[i]) g = 4'b0001 << i;
      mstim = g;
      mpend = (mpend & ~g) | ev;
    end
  endtask

  task automatic tick(input logic [3:0] k, input logic [3:0] k2, input logic r);
    key_n = k; key2 = k2; reset_n = r;
    @(posedge clock);
    model_edge(k, r);
    @(negedge clock);
    chk("model_stim", stimulus, mstim);
    chk("model_pend", pending, mpend);
    chk_int("onehot", ($countones(stimulus) > 1) ? 1 : 0, 0);
  endtask

  task automatic rel(input int n);
    repeat (n) tick(F, F, 1'b1);
  endtask

  task automatic run_tab(input string n, input vec_t t[$]);
    foreach (t[i]) begin
      tick(t[i].k, F, 1'b1);
      chk({n, "_stim"}, stimulus, t[i].s);
      chk({n, "_pend"}, pending, t[i].p);
    end
  endtask

  initial begin
    int pulses, nz, at;
    logic [3:0] kv;
    int hold[4];
    for (int i = 1; i <= 10; i++)
      tv.push_back('{4'b1011, (i == 7) ? 4'b0100 : 4'b0000, (i == 6) ? 4'b0100 : 4'b0000});
    for (int i = 0; i < 8; i++) tv.push_back('{F, 4'b0000, 4'b0000});
    for (int i = 1; i <= 5; i++) sim.push_back('{4'b0000, 4'b0000, 4'b0000});
    sim.push_back('{4'b0000, 4'b0000, 4'b1111});
    sim.push_back('{4'b0000, 4'b1000, 4'b0111});
    sim.push_back('{4'b0000, 4'b0100, 4'b0011});
    sim.push_back('{4'b0000, 4'b0010, 4'b0001});
    sim.push_back('{4'b0000, 4'b0001, 4'b0000});
    sw.push_back('{4'b0000, 4'b0000, 4'b0000});
    sw.push_back('{4'b0000, 4'b0000, 4'b0000});
    sw.push_back('{4'b0001, 4'b0000, 4'b0000});
    sw.push_back('{4'b0001, 4'b0000, 4'b1111});
    sw.push_back('{4'b0000, 4'b1000, 4'b0111});
    sw.push_back('{4'b0000, 4'b0100, 4'b0011});
    sw.push_back('{4'b0000, 4'b0010, 4'b0001});
    sw.push_back('{4'b0000, 4'b0001, 4'b0001});
    sw.push_back('{4'b0000, 4'b0001, 4'b0000});
    sw.push_back('{4'b0000, 4'b0000, 4'b0000});

    tick(F, F, 1'b0); tick(F, F, 1'b0);
    chk("reset_stim", stimulus, 4'b0000);
    chk("reset_pend", pending, 4'b0000);
    rel(8);
    run_tab("clean", tv);

    pulses = 0; nz = 0; at = 0;
    for (int i = 0; i < 15; i++) begin
      tick((i == 2) ? F : 4'b0111, F, 1'b1);
      if (stimulus != 0) nz++;
      if (stimulus == 4'b1000) begin pulses++; at = i - 2; end
    end
    chk_int("bounce_pulses", pulses, 1);
    chk_int("bounce_any", nz, 1);
    chk_int("bounce_latency", at, 7);
    rel(8);

    run_tab("simul", sim);
    rel(8);

    tick(4'b1110, F, 1'b0); tick(4'b1110, F, 1'b0);
    nz = 0;
    repeat (14) begin tick(4'b1110, F, 1'b1); if (stimulus != 0) nz++; end
    chk_int("held_reset_none", nz, 0);
    rel(6);
    pulses = 0; nz = 0;
    repeat (10) begin
      tick(4'b1110, F, 1'b1);
      if (stimulus != 0) nz++;
      if (stimulus == 4'b0001) pulses++;
    end
    chk_int("held_repress", pulses, 1);
    chk_int("held_repress_any", nz, 1);
    rel(8);

    repeat (3) tick(4'b1101, F, 1'b1);
    tick(4'b1101, F, 1'b0);
    chk("midreset_stim", stimulus, 4'b0000);
    chk("midreset_pend", pending, 4'b0000);
    nz = 0;
    repeat (10) begin tick(4'b1101, F, 1'b1); if (stimulus != 0 || pending != 0) nz++; end
    chk_int("midreset_quiet", nz, 0);
    rel(8);

    foreach (sw[i]) begin
      tick(F, sw[i].k, 1'b1);
      chk("setwins_stim", stim2, sw[i].s);
      chk("setwins_pend", pend2, sw[i].p);
    end
    rel(8);

    kv = F;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    repeat (1500) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          kv[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
        hold[i]--;
      end
      tick(kv, F, ($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
